// File: rtl/trigger_frame_checker.sv
// Trigger frame checker: validates AXI-Stream trigger frames made of a
// header beat, a run of numbered body lines and a footer beat, and keeps
// per-frame verdicts, good/bad frame counters and sticky error flags.
module trigger_frame_checker #(
  parameter int DATA_WIDTH      = 128,
  parameter int DEFAULT_MAX_LEN = 16
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    SET_CONFIG,
  input  logic [15:0]             MAX_TRIGGER_LENGTH,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                    S_AXIS_tvalid,
  output logic                    S_AXIS_tready,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tlast,
  output logic                    FRAME_DONE,
  output logic                    FRAME_OK,
  output logic [15:0]             FRAME_LINES,
  output logic [31:0]             GOOD_CNT,
  output logic [31:0]             BAD_CNT,
  output logic [4:0]              ERR_FLAGS
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int LANES  = DATA_WIDTH / 16;

  localparam logic [7:0]        HEADER_BYTE = 8'hAA;
  localparam logic [7:0]        FOOTER_BYTE = 8'h55;
  localparam logic [KEEP_W-1:0] BODY_KEEP   = {KEEP_W{1'b1}};
  // Footer carries only its upper half of bytes.
  localparam logic [KEEP_W-1:0] FOOTER_KEEP = {{(KEEP_W/2){1'b1}}, {(KEEP_W/2){1'b0}}};

  // Error bit positions inside ERR_FLAGS and the per-frame error vector.
  localparam int E_HDR  = 0;
  localparam int E_FTR  = 1;
  localparam int E_LEN  = 2;
  localparam int E_KEEP = 3;
  localparam int E_PAT  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DROP
  } state_t;

  state_t      state_reg, state_next;
  logic [16:0] lines_reg, lines_next;   // one extra bit so max+1 never wraps
  logic [4:0]  ferr_reg, ferr_next;     // errors of the frame in flight
  logic [15:0] max_reg;
  logic        ready_reg;

  logic              beat;
  logic [16:0]       line_num;
  logic              line_over;
  logic              hdr_bad;
  logic              ftr_bad;
  logic              keep_bad;
  logic              pat_bad;
  logic [LANES-1:0]  lane_bad;
  logic              done_now;
  logic [4:0]        done_err;
  logic [16:0]       done_lines;

  assign S_AXIS_tready = ready_reg & ~SET_CONFIG;
  assign beat          = S_AXIS_tvalid & S_AXIS_tready;

  // Number the current beat would get if it were a body line.
  assign line_num  = lines_reg + 17'd1;
  assign line_over = line_num > {1'b0, max_reg};

  assign hdr_bad  = S_AXIS_tdata[DATA_WIDTH-1 -: 8] != HEADER_BYTE;
  assign ftr_bad  = (S_AXIS_tdata[DATA_WIDTH-1 -: 8] != FOOTER_BYTE) ||
                    (S_AXIS_tkeep != FOOTER_KEEP);
  assign keep_bad = S_AXIS_tkeep != BODY_KEEP;
  assign pat_bad  = |lane_bad;

  // Lane j of body line k must hold (k + j) mod 2^16.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bad[gi] = S_AXIS_tdata[16*gi +: 16] != (line_num[15:0] + 16'(gi));
    end
  endgenerate

  // Next-state and per-frame error accumulation for each accepted beat.
  always_comb begin
    state_next = state_reg;
    lines_next = lines_reg;
    ferr_next  = ferr_reg;
    done_now   = 1'b0;
    done_err   = ferr_reg;
    done_lines = lines_reg;
    if (beat) begin
      case (state_reg)
        IDLE: begin
          if (S_AXIS_tlast) begin
            // A lone tlast beat is neither a valid header nor a valid frame.
            done_now   = 1'b1;
            done_err   = 5'b0;
            done_err[E_HDR] = 1'b1;
            done_err[E_FTR] = 1'b1;
            done_lines = 17'd0;
            lines_next = 17'd0;
          end else begin
            state_next = BODY;
            lines_next = 17'd0;
            ferr_next  = 5'b0;
            ferr_next[E_HDR] = hdr_bad;
          end
        end
        BODY, DROP: begin
          if (S_AXIS_tlast) begin
            done_now   = 1'b1;
            done_err   = ferr_reg;
            done_err[E_FTR] = ferr_reg[E_FTR] | ftr_bad;
            done_err[E_LEN] = ferr_reg[E_LEN] | (lines_reg == 17'd0);
            done_lines = lines_reg;
            state_next = IDLE;
          end else if (state_reg == BODY) begin
            lines_next = line_num;
            if (line_over) begin
              // Overlong frame: count this line once, then discard the rest.
              ferr_next[E_LEN] = 1'b1;
              state_next       = DROP;
            end else begin
              ferr_next[E_KEEP] = ferr_reg[E_KEEP] | keep_bad;
              ferr_next[E_PAT]  = ferr_reg[E_PAT] | pat_bad;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame tracking state and configuration register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg <= IDLE;
      lines_reg <= 17'd0;
      ferr_reg  <= 5'b0;
      max_reg   <= 16'(DEFAULT_MAX_LEN);
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (SET_CONFIG) begin
        state_reg <= IDLE;
        lines_reg <= 17'd0;
        ferr_reg  <= 5'b0;
        max_reg   <= MAX_TRIGGER_LENGTH;
      end else begin
        state_reg <= state_next;
        lines_reg <= lines_next;
        ferr_reg  <= ferr_next;
      end
    end
  end

  // Verdict, statistics and sticky error reporting on frame completion.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      FRAME_DONE  <= 1'b0;
      FRAME_OK    <= 1'b0;
      FRAME_LINES <= 16'd0;
      GOOD_CNT    <= 32'd0;
      BAD_CNT     <= 32'd0;
      ERR_FLAGS   <= 5'b0;
    end else if (SET_CONFIG) begin
      FRAME_DONE  <= 1'b0;
      FRAME_OK    <= 1'b0;
      FRAME_LINES <= 16'd0;
      GOOD_CNT    <= 32'd0;
      BAD_CNT     <= 32'd0;
      ERR_FLAGS   <= 5'b0;
    end else begin
      FRAME_DONE <= done_now;
      if (done_now) begin
        FRAME_OK    <= (done_err == 5'b0);
        FRAME_LINES <= done_lines[16] ? 16'hFFFF : done_lines[15:0];
        ERR_FLAGS   <= ERR_FLAGS | done_err;
        if (done_err == 5'b0) begin
          if (GOOD_CNT != 32'hFFFF_FFFF) GOOD_CNT <= GOOD_CNT + 32'd1;
        end else begin
          if (BAD_CNT != 32'hFFFF_FFFF) BAD_CNT <= BAD_CNT + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_frame_checker.sv
// Bench for trigger_frame_checker: directed frames, a frame-level reference
// model checked every cycle, and literal expectations for key scenarios.
module tb_trigger_frame_checker;

  logic         CLK;
  logic         RESETN;
  logic         SET_CONFIG;
  logic [15:0]  MAX_TRIGGER_LENGTH;
  logic [127:0] S_AXIS_tdata;
  logic         S_AXIS_tvalid;
  logic         S_AXIS_tready;
  logic [15:0]  S_AXIS_tkeep;
  logic         S_AXIS_tlast;
  logic         FRAME_DONE;
  logic         FRAME_OK;
  logic [15:0]  FRAME_LINES;
  logic [31:0]  GOOD_CNT;
  logic [31:0]  BAD_CNT;
  logic [4:0]   ERR_FLAGS;

  trigger_frame_checker #(
    .DATA_WIDTH(128),
    .DEFAULT_MAX_LEN(16)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .SET_CONFIG(SET_CONFIG),
    .MAX_TRIGGER_LENGTH(MAX_TRIGGER_LENGTH),
    .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tkeep(S_AXIS_tkeep),
    .S_AXIS_tlast(S_AXIS_tlast),
    .FRAME_DONE(FRAME_DONE),
    .FRAME_OK(FRAME_OK),
    .FRAME_LINES(FRAME_LINES),
    .GOOD_CNT(GOOD_CNT),
    .BAD_CNT(BAD_CNT),
    .ERR_FLAGS(ERR_FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_pulses = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Judge a whole captured frame directly from the frame-format rules.
  function automatic void eval_frame(input beat_t q[$], input int mx,
                                     output logic [4:0] e, output int ln);
    int n;
    int nb;
    int checked;
    n  = q.size();
    e  = 5'b0;
    ln = 0;
    if (n == 1) begin
      e = 5'b00011;
      return;
    end
    if (q[0].d[127:120] != 8'hAA) e[0] = 1'b1;
    nb = n - 2;
    if (nb == 0) e[2] = 1'b1;
    if (nb > mx) begin
      e[2]    = 1'b1;
      ln      = mx + 1;
      checked = mx;
    end else begin
      ln      = nb;
      checked = nb;
    end
    for (int k = 1; k <= checked; k++) begin
      if (q[k].k != 16'hFFFF) e[3] = 1'b1;
      for (int j = 0; j < 8; j++)
        if (q[k].d[16*j +: 16] != 16'(k + j)) e[4] = 1'b1;
    end
    if (q[n-1].d[127:120] != 8'h55 || q[n-1].k != 16'hFF00) e[1] = 1'b1;
  endfunction

  // Reference model state.
  beat_t       frame_q[$];
  int          m_max = 16;
  logic        m_ready = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_ok = 1'b0;
  logic [15:0] exp_lines = 16'd0;
  logic [31:0] exp_good = 32'd0;
  logic [31:0] exp_bad = 32'd0;
  logic [4:0]  exp_err = 5'b0;

  // Compare process: check outputs mid-cycle, then predict the next edge.
  initial begin
    logic        exp_ready;
    logic [4:0]  fe;
    int          fl;
    beat_t       b;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        frame_q.delete();
        m_max = 16; m_ready = 1'b0;
        exp_done = 1'b0; exp_ok = 1'b0; exp_lines = 16'd0;
        exp_good = 32'd0; exp_bad = 32'd0; exp_err = 5'b0;
      end
      exp_ready = m_ready && !SET_CONFIG;
      check("tready",      32'(S_AXIS_tready), 32'(exp_ready));
      check("frame_done",  32'(FRAME_DONE),    32'(exp_done));
      check("frame_ok",    32'(FRAME_OK),      32'(exp_ok));
      check("frame_lines", 32'(FRAME_LINES),   32'(exp_lines));
      check("good_cnt",    GOOD_CNT,           exp_good);
      check("bad_cnt",     BAD_CNT,            exp_bad);
      check("err_flags",   32'(ERR_FLAGS),     32'(exp_err));
      if (FRAME_DONE) begin
        done_pulses++;
        $display("frame %0d done: ok=%0d lines=%0d good=%0d bad=%0d flags=%05b",
                 done_pulses, FRAME_OK, FRAME_LINES, GOOD_CNT, BAD_CNT, ERR_FLAGS);
      end
      if (RESETN) begin
        exp_done = 1'b0;
        if (SET_CONFIG) begin
          m_max = int'(MAX_TRIGGER_LENGTH);
          frame_q.delete();
          exp_ok = 1'b0; exp_lines = 16'd0;
          exp_good = 32'd0; exp_bad = 32'd0; exp_err = 5'b0;
        end else if (S_AXIS_tvalid && exp_ready) begin
          b.d = S_AXIS_tdata; b.k = S_AXIS_tkeep; b.l = S_AXIS_tlast;
          frame_q.push_back(b);
          if (S_AXIS_tlast) begin
            eval_frame(frame_q, m_max, fe, fl);
            frame_q.delete();
            exp_done  = 1'b1;
            exp_ok    = (fe == 5'b0);
            exp_lines = 16'(fl);
            exp_err   = exp_err | fe;
            if (fe == 5'b0) begin
              if (exp_good != 32'hFFFF_FFFF) exp_good = exp_good + 1;
            end else begin
              if (exp_bad != 32'hFFFF_FFFF) exp_bad = exp_bad + 1;
            end
          end
        end
        m_ready = 1'b1;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] body_data(input int k);
    logic [127:0] d;
    for (int j = 0; j < 8; j++) d[16*j +: 16] = 16'(k + j);
    return d;
  endfunction

  // Present one beat (after optional idle cycles) and hold until accepted.
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k,
                           input logic l, input int gap);
    logic acc;
    int   tries;
    repeat (gap) begin
      S_AXIS_tvalid = 1'b0;
      @(posedge CLK); #1;
    end
    S_AXIS_tdata  = d;
    S_AXIS_tkeep  = k;
    S_AXIS_tlast  = l;
    S_AXIS_tvalid = 1'b1;
    tries = 0;
    do begin
      @(negedge CLK);
      acc = S_AXIS_tready;
      @(posedge CLK); #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL handshake: got no tready in %0d cycles, expected acceptance", tries);
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hb, input int nl, input int bad_line,
                            input int bad_lane, input logic [7:0] fb,
                            input logic [15:0] fk, input bit gaps);
    logic [127:0] d;
    send_beat({hb, 120'h0}, 16'hFFFF, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
    for (int k = 1; k <= nl; k++) begin
      d = body_data(k);
      if (k == bad_line) d[16*bad_lane +: 16] = 16'h0000;
      send_beat(d, 16'hFFFF, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
    end
    send_beat({fb, 120'h0}, fk, 1'b1, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic good_frame(input int nl, input bit gaps);
    send_frame(8'hAA, nl, 0, 0, 8'h55, 16'hFF00, gaps);
  endtask

  // One-cycle configuration pulse; tready must drop while it is high.
  task automatic do_config(input logic [15:0] mx);
    SET_CONFIG = 1'b1;
    MAX_TRIGGER_LENGTH = mx;
    @(negedge CLK);
    check("cfg_tready_low", 32'(S_AXIS_tready), 32'd0);
    @(posedge CLK); #1;
    SET_CONFIG = 1'b0;
  endtask

  initial begin
    int p0;
    RESETN = 1'b0;
    SET_CONFIG = 1'b0;
    MAX_TRIGGER_LENGTH = 16'd0;
    S_AXIS_tdata = '0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tkeep = '0;
    S_AXIS_tlast = 1'b0;

    // Reset state and tready rising one edge after release.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tready", 32'(S_AXIS_tready), 32'd0);
    check("rst_good",   GOOD_CNT, 32'd0);
    check("rst_flags",  32'(ERR_FLAGS), 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    check("tready_before_edge", 32'(S_AXIS_tready), 32'd0);
    @(posedge CLK); #1;
    check("tready_after_edge", 32'(S_AXIS_tready), 32'd1);

    // Ten back-to-back good frames of four lines at the default max.
    p0 = done_pulses;
    for (int i = 0; i < 10; i++) good_frame(4, 1'b0);
    check("ten_done_now", 32'(FRAME_DONE), 32'd1);
    check("ten_ok",    32'(FRAME_OK), 32'd1);
    check("ten_lines", 32'(FRAME_LINES), 32'd4);
    check("ten_good",  GOOD_CNT, 32'd10);
    check("ten_bad",   BAD_CNT, 32'd0);
    check("ten_flags", 32'(ERR_FLAGS), 32'd0);
    @(negedge CLK);
    check("ten_pulses", 32'(done_pulses - p0), 32'd10);
    @(posedge CLK); #1;

    // Bad header byte, then a good frame: flags stay sticky.
    do_config(16'd16);
    send_frame(8'hAB, 3, 0, 0, 8'h55, 16'hFF00, 1'b0);
    check("hdr_ok",    32'(FRAME_OK), 32'd0);
    check("hdr_bad",   BAD_CNT, 32'd1);
    check("hdr_flags", 32'(ERR_FLAGS), 32'h01);
    good_frame(3, 1'b0);
    check("hdr_next_good",  GOOD_CNT, 32'd1);
    check("hdr_next_flags", 32'(ERR_FLAGS), 32'h01);

    // Max four lines, six sent: counted lines saturate at five.
    do_config(16'd4);
    good_frame(6, 1'b0);
    check("len_lines", 32'(FRAME_LINES), 32'd5);
    check("len_flags", 32'(ERR_FLAGS), 32'h04);
    check("len_bad",   BAD_CNT, 32'd1);

    // Line 2 lane 3 zeroed and a full-keep footer.
    do_config(16'd16);
    send_frame(8'hAA, 3, 2, 3, 8'h55, 16'hFFFF, 1'b0);
    check("pat_flags", 32'(ERR_FLAGS), 32'h12);
    check("pat_bad",   BAD_CNT, 32'd1);

    // Header followed directly by footer, then a lone tlast beat.
    do_config(16'd16);
    good_frame(0, 1'b0);
    check("empty_flags", 32'(ERR_FLAGS), 32'h04);
    send_beat({8'hAA, 120'h0}, 16'hFF00, 1'b1, 0);
    check("lone_flags", 32'(ERR_FLAGS), 32'h07);
    check("lone_lines", 32'(FRAME_LINES), 32'd0);

    // Max zero: the first body line already overflows.
    do_config(16'd0);
    good_frame(2, 1'b0);
    check("max0_lines", 32'(FRAME_LINES), 32'd1);
    check("max0_flags", 32'(ERR_FLAGS), 32'h04);

    // Random gaps on good frames.
    do_config(16'd16);
    for (int i = 0; i < 5; i++) good_frame(1 + i, 1'b1);
    check("gap_good",  GOOD_CNT, 32'd5);
    check("gap_flags", 32'(ERR_FLAGS), 32'h00);

    // Configuration pulse in the middle of a frame aborts it.
    send_beat({8'hAA, 120'h0}, 16'hFFFF, 1'b0, 0);
    send_beat(body_data(1), 16'hFFFF, 1'b0, 0);
    do_config(16'd16);
    check("abort_good", GOOD_CNT, 32'd0);
    check("abort_bad",  BAD_CNT, 32'd0);
    good_frame(2, 1'b0);
    check("abort_next_good", GOOD_CNT, 32'd1);
    check("abort_next_bad",  BAD_CNT, 32'd0);

    // Asynchronous reset mid-frame, between clock edges.
    send_beat({8'hAA, 120'h0}, 16'hFFFF, 1'b0, 0);
    send_beat(body_data(1), 16'hFFFF, 1'b0, 0);
    #2;
    RESETN = 1'b0;
    #1;
    check("arst_good",   GOOD_CNT, 32'd0);
    check("arst_lines",  32'(FRAME_LINES), 32'd0);
    check("arst_tready", 32'(S_AXIS_tready), 32'd0);
    @(negedge CLK);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    good_frame(4, 1'b0);
    check("arst_next_good", GOOD_CNT, 32'd1);
    check("arst_next_ok",   32'(FRAME_OK), 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
